mure_repacker: RTL and testbench

- Inverse of the retirement serializer. Accepts a one-instruction-per-beat retirement stream with valid/ready handshake.
- Repacks the stream into NrRetiredInstr-wide bundles that carry per-slot data, a slot-valid mask and one set of common fields.
- Sits on the trace decoder/checker side, and in benches that compare against CVA6 multi-port commit.

---
 rtl/mure_pkg.sv | 35 +++
 rtl/mure_repack_timeout.sv | 29 ++
 rtl/mure_repacker.sv | 150 +++++++++++++++
 tb/tb_mure_repacker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared widths, instruction-type codes and entry structs for the MURE trace path.
// bundle_s describes one repacked multi-slot bundle at the default slot count.
package mure_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 7;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

  localparam int unsigned DEFAULT_NR_RETIRED = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  typedef struct packed {
    uop_entry_s [DEFAULT_NR_RETIRED-1:0] slot;
    logic [DEFAULT_NR_RETIRED-1:0]       mask;
    common_entry_s                       common;
  } bundle_s;

endpackage

// File: rtl/mure_repack_timeout.sv
// Saturating idle counter that closes a partial bundle after a quiet period.
// A restart clears the count; the expire pulse fires while enabled at the last idle cycle.
module mure_repack_timeout #(
  parameter int unsigned TimeoutCycles = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CntW'(TimeoutCycles))) begin
      r_count <= r_count + CntW'(1);
    end
  end

  assign o_expire = i_enable && (r_count == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/mure_repacker.sv
// Repacks a one-instruction-per-beat retirement stream into NrRetiredInstr-wide bundles
// through an accumulator stage followed by an output register stage.
module mure_repacker
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned TimeoutCycles  = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       valid_i,
  output logic                                       ready_o,
  input  logic [IRETIRE_LEN-1:0]                     iretire_i,
  input  logic                                       ilastsize_i,
  input  logic [ITYPE_LEN-1:0]                       itype_i,
  input  logic [XLEN-1:0]                            iaddr_i,
  input  logic [CAUSE_LEN-1:0]                       cause_i,
  input  logic [XLEN-1:0]                            tval_i,
  input  logic [PRIV_LEN-1:0]                        priv_i,
  input  logic                                       flush_i,
  output logic                                       valid_o,
  input  logic                                       ready_i,
  output logic [NrRetiredInstr-1:0]                  slot_valid_o,
  output logic [NrRetiredInstr-1:0][IRETIRE_LEN-1:0] iretire_o,
  output logic [NrRetiredInstr-1:0]                  ilastsize_o,
  output logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]   itype_o,
  output logic [NrRetiredInstr-1:0][XLEN-1:0]        iaddr_o,
  output logic [CAUSE_LEN-1:0]                       cause_o,
  output logic [XLEN-1:0]                            tval_o,
  output logic [PRIV_LEN-1:0]                        priv_o
);

  localparam int unsigned      CntW     = $clog2(NrRetiredInstr + 1);
  localparam logic [CntW-1:0]  LastSlot = CntW'(NrRetiredInstr - 1);

  logic [CntW-1:0]                    r_accCnt;
  logic                               r_accClosed;
  uop_entry_s [NrRetiredInstr-1:0]    r_accSlot;
  logic [NrRetiredInstr-1:0]          r_accMask;
  common_entry_s                      r_accCommon;

  logic                               r_outValid;
  uop_entry_s [NrRetiredInstr-1:0]    r_outSlot;
  logic [NrRetiredInstr-1:0]          r_outMask;
  common_entry_s                      r_outCommon;

  uop_entry_s    w_beat;
  common_entry_s w_common;
  logic          w_mismatch;
  logic          w_accept;
  logic          w_write;
  logic          w_trap;
  logic          w_close;
  logic          w_transfer;
  logic          w_expire;
  logic          w_tmoEnable;
  logic          w_tmoRestart;

  assign w_beat   = '{iretire: iretire_i, ilastsize: ilastsize_i, itype: itype_i, iaddr: iaddr_i};
  assign w_common = '{cause: cause_i, tval: tval_i, priv: priv_i};

  // A beat whose common fields differ from the open bundle must wait for a fresh bundle.
  assign w_mismatch = (r_accCnt != '0) && (w_common != r_accCommon);
  assign ready_o    = !r_accClosed && !w_mismatch;
  assign w_accept   = valid_i && ready_o;
  assign w_write    = w_accept && (iretire_i != '0);
  assign w_trap     = (itype_i == ITYPE_EXC) || (itype_i == ITYPE_INT);
  assign w_transfer = r_accClosed && (!r_outValid || ready_i);

  assign w_close = (w_write && ((r_accCnt == LastSlot) || w_trap))
                || (valid_i && w_mismatch)
                || (flush_i && (r_accCnt != '0))
                || w_expire;

  assign w_tmoEnable  = (r_accCnt != '0) && !r_accClosed && !w_accept;
  assign w_tmoRestart = w_write || w_transfer;

  mure_repack_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_restart(w_tmoRestart),
    .i_enable (w_tmoEnable),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || w_transfer) begin
      r_accCnt    <= '0;
      r_accClosed <= 1'b0;
      r_accSlot   <= '0;
      r_accMask   <= '0;
      r_accCommon <= '0;
    end else begin
      if (w_write) begin
        for (int i = 0; i < NrRetiredInstr; i++) begin
          if (r_accCnt == CntW'(i)) begin
            r_accSlot[i] <= w_beat;
            r_accMask[i] <= 1'b1;
          end
        end
        if (r_accCnt == '0) begin
          r_accCommon <= w_common;
        end
        r_accCnt <= r_accCnt + CntW'(1);
      end
      if (w_close) begin
        r_accClosed <= 1'b1;
      end
    end
  end

  // Output stage keeps its data after a pop; only valid drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outValid  <= 1'b0;
      r_outSlot   <= '0;
      r_outMask   <= '0;
      r_outCommon <= '0;
    end else if (w_transfer) begin
      r_outValid  <= 1'b1;
      r_outSlot   <= r_accSlot;
      r_outMask   <= r_accMask;
      r_outCommon <= r_accCommon;
    end else if (r_outValid && ready_i) begin
      r_outValid <= 1'b0;
    end
  end

  always_comb begin
    iretire_o   = '0;
    ilastsize_o = '0;
    itype_o     = '0;
    iaddr_o     = '0;
    for (int i = 0; i < NrRetiredInstr; i++) begin
      iretire_o[i]   = r_outSlot[i].iretire;
      ilastsize_o[i] = r_outSlot[i].ilastsize;
      itype_o[i]     = r_outSlot[i].itype;
      iaddr_o[i]     = r_outSlot[i].iaddr;
    end
  end

  assign valid_o      = r_outValid;
  assign slot_valid_o = r_outMask;
  assign cause_o      = r_outCommon.cause;
  assign tval_o       = r_outCommon.tval;
  assign priv_o       = r_outCommon.priv;

endmodule

// File: tb/tb_mure_repacker.sv
// Directed scoreboard bench for mure_repacker with two slots and an eight-cycle timeout.
// Tests push hand-computed bundles; an independent monitor pops and compares on each handshake.
module tb_mure_repacker;

  localparam int unsigned TMO = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [6:0]       iretire_i;
  logic             ilastsize_i;
  logic [2:0]       itype_i;
  logic [31:0]      iaddr_i;
  logic [4:0]       cause_i;
  logic [31:0]      tval_i;
  logic [1:0]       priv_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [1:0]       slot_valid_o;
  logic [1:0][6:0]  iretire_o;
  logic [1:0]       ilastsize_o;
  logic [1:0][2:0]  itype_o;
  logic [1:0][31:0] iaddr_o;
  logic [4:0]       cause_o;
  logic [31:0]      tval_o;
  logic [1:0]       priv_o;

  typedef struct packed {
    logic [1:0]       mask;
    logic [1:0][6:0]  iret;
    logic [1:0]       ilast;
    logic [1:0][2:0]  itype;
    logic [1:0][31:0] iaddr;
    logic [4:0]       cause;
    logic [31:0]      tval;
    logic [1:0]       priv;
  } bundle_t;

  bundle_t expQ[$];
  int      assertions = 0;
  int      failures   = 0;

  mure_repacker #(.NrRetiredInstr(2), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
    .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .slot_valid_o(slot_valid_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
    .itype_o(itype_o), .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic bundle_t mkBundle(input logic [1:0] mask, input logic [31:0] a1,
                                       input logic [31:0] a0, input logic [6:0] r1,
                                       input logic [6:0] r0, input logic [2:0] t1,
                                       input logic [2:0] t0, input logic [4:0] cause,
                                       input logic [31:0] tval, input logic [1:0] priv);
    bundle_t b;
    b.mask     = mask;
    b.iret[1]  = r1;
    b.iret[0]  = r0;
    b.ilast    = mask;
    b.itype[1] = t1;
    b.itype[0] = t0;
    b.iaddr[1] = a1;
    b.iaddr[0] = a0;
    b.cause    = cause;
    b.tval     = tval;
    b.priv     = priv;
    return b;
  endfunction

  // Drives one beat from just after a rising edge and returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [6:0] iret,
                               input logic [2:0] ityp, input logic [4:0] cause,
                               input logic [31:0] tval, input logic [1:0] priv,
                               output logic firstReady);
    int waits = 0;
    valid_i     = 1'b1;
    iaddr_i     = addr;
    iretire_i   = iret;
    itype_i     = ityp;
    cause_i     = cause;
    tval_i      = tval;
    priv_i      = priv;
    ilastsize_i = 1'b1;
    @(negedge clk);
    firstReady = ready_o;
    while (!ready_o && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready_o) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: beat %h got ready_o=0 expected 1", addr);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || valid_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      assertions++;
      failures++;
      $display("[TB] FAIL idle_timeout: got %0d pending expected 0", expQ.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected bundle.
  initial begin
    bundle_t act;
    bundle_t exp;
    forever begin
      @(negedge clk);
      if (!rst_i && valid_o && ready_i) begin
        act = {slot_valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o};
        if (expQ.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_bundle: got %h expected none", act);
        end else begin
          exp = expQ.pop_front();
          checkOutput("bundle", act, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rdy;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    iretire_i = '0; ilastsize_i = 1'b0; itype_i = '0; iaddr_i = '0;
    cause_i = '0; tval_i = '0; priv_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_mask", slot_valid_o, 0);
    checkOutput("reset_ready", ready_o, 1);
    checkOutput("reset_iaddr", iaddr_o, 0);
    @(posedge clk);
    #1;

    // Back-to-back pair fills the bundle; ready_o drops for the one closed cycle.
    expQ.push_back(mkBundle(2'b11, 32'h104, 32'h100, 7'd2, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h100, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h104, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    checkOutput("pair_second_ready", rdy, 1);
    @(negedge clk);
    checkOutput("pair_closed_ready", ready_o, 0);
    @(negedge clk);
    checkOutput("pair_ready_back", ready_o, 1);
    checkOutput("pair_valid", valid_o, 1);
    waitIdle();

    // Exception in slot 1, interrupt in slot 1, and a lone exception in slot 0.
    expQ.push_back(mkBundle(2'b11, 32'h204, 32'h200, 7'd2, 7'd2, 3'd1, 3'd0, 5'd2, 32'h55, 2'd3));
    applyStimulus(32'h200, 7'd2, 3'd0, 5'd2, 32'h55, 2'd3, rdy);
    applyStimulus(32'h204, 7'd2, 3'd1, 5'd2, 32'h55, 2'd3, rdy);
    expQ.push_back(mkBundle(2'b11, 32'h304, 32'h300, 7'd2, 7'd4, 3'd2, 3'd0, 5'd7, 32'h0, 2'd0));
    applyStimulus(32'h300, 7'd4, 3'd0, 5'd7, 32'h0, 2'd0, rdy);
    applyStimulus(32'h304, 7'd2, 3'd2, 5'd7, 32'h0, 2'd0, rdy);
    expQ.push_back(mkBundle(2'b01, 32'h0, 32'h310, 7'd0, 7'd2, 3'd0, 3'd1, 5'd3, 32'h9, 2'd1));
    applyStimulus(32'h310, 7'd2, 3'd1, 5'd3, 32'h9, 2'd1, rdy);
    waitIdle();

    // Lone beat closes by timeout: not before TMO edges, present shortly after.
    expQ.push_back(mkBundle(2'b01, 32'h0, 32'h400, 7'd0, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h400, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    repeat (TMO) @(negedge clk);
    checkOutput("timeout_not_early", valid_o, 0);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 2 && !seen; k++) begin
        @(negedge clk);
        seen = valid_o;
      end
      checkOutput("timeout_emitted", seen, 1);
    end
    waitIdle();

    // Privilege change stalls the beat, closes {A}; flush then closes {B}.
    expQ.push_back(mkBundle(2'b01, 32'h0, 32'h500, 7'd0, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd3));
    expQ.push_back(mkBundle(2'b01, 32'h0, 32'h504, 7'd0, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h500, 7'd2, 3'd0, 5'd0, 32'h0, 2'd3, rdy);
    applyStimulus(32'h504, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    checkOutput("mismatch_blocks", rdy, 0);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    waitIdle();

    // Flush with an empty accumulator produces nothing.
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("flush_empty_valid", valid_o, 0);
    checkOutput("flush_empty_ready", ready_o, 1);
    @(posedge clk);
    #1;

    // Backpressure: second bundle closes behind a held one, then both drain.
    ready_i = 1'b0;
    expQ.push_back(mkBundle(2'b11, 32'h604, 32'h600, 7'd2, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    expQ.push_back(mkBundle(2'b11, 32'h60c, 32'h608, 7'd1, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h600, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h604, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h608, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h60c, 7'd1, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_ready", ready_o, 0);
      checkOutput("stall_valid", valid_o, 1);
      checkOutput("stall_iaddr", iaddr_o, {32'h604, 32'h600});
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    waitIdle();

    // Zero-retire beat is dropped without taking a slot.
    expQ.push_back(mkBundle(2'b11, 32'h908, 32'h900, 7'd2, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h900, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h904, 7'd0, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h908, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    waitIdle();

    // Reset with one held beat and stale output data clears everything.
    applyStimulus(32'h700, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_valid", valid_o, 0);
    checkOutput("rst_mid_mask", slot_valid_o, 0);
    checkOutput("rst_mid_iaddr", iaddr_o, 0);
    checkOutput("rst_mid_iretire", iretire_o, 0);
    checkOutput("rst_mid_ready", ready_o, 1);
    @(posedge clk);
    #1;
    expQ.push_back(mkBundle(2'b11, 32'h804, 32'h800, 7'd2, 7'd2, 3'd0, 3'd0, 5'd0, 32'h0, 2'd0));
    applyStimulus(32'h800, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    applyStimulus(32'h804, 7'd2, 3'd0, 5'd0, 32'h0, 2'd0, rdy);
    waitIdle();

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
